atmega_exint: RTL and testbench
===============================

Name: atmega_exint

Overview:
- ATmega external-interrupt and pin-change-interrupt controller (EICRA/EIMSK/EIFR, PCICR/PCIFR/PCMSK).
- Reads the pin side of a port: samples the same `io_i` pins the PIO block drives and reads.
- Raises interrupt requests to the AVR core's interrupt vector logic.
- Sits on the core's 8-bit I/O register bus alongside the PIO blocks.

Parameters:
- BUS_ADDR_DATA_LEN, 8, I/O address width.
- PORT_WIDTH, 8, number of pin-change inputs.
- EXT_WIDTH, 2, number of INTn lines (1..4).
- EICRA_ADDR, 'h69, sense-control register address.
- EIMSK_ADDR, 'h3D, INTn enable register address.
- EIFR_ADDR, 'h3C, INTn flag register address.
- PCICR_ADDR, 'h68, pin-change enable register address (bit0).
- PCIFR_ADDR, 'h3B, pin-change flag register address (bit0).
- PCMSK_ADDR, 'h6B, per-pin pin-change mask register address.
- PINMASK, 'hFF, implemented pin-change inputs; unimplemented bits read 0 and never trigger.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous, active-low reset.
- addr_i  in  BUS_ADDR_DATA_LEN  I/O address.
- wr_i  in  1  register write strobe.
- rd_i  in  1  register read strobe.
- bus_i  in  8  write data.
- bus_o  out  8  read data (combinational).
- io_i  in  PORT_WIDTH  asynchronous pin-change inputs.
- int_i  in  EXT_WIDTH  asynchronous INTn inputs.
- int_req_o  out  EXT_WIDTH  INTn interrupt requests.
- int_ack_i  in  EXT_WIDTH  vector-taken acknowledge per INTn.
- pcint_req_o  out  1  pin-change interrupt request.
- pcint_ack_i  in  1  pin-change vector-taken acknowledge.

Behaviour:
- Reset, sampled on a clk_i edge with rst_i=0:
  - EICRA, EIMSK, EIFR, PCICR, PCIFR, PCMSK and the arm counter all clear to 0.
  - Sync flops load the current raw inputs.
  - int_req_o=0, pcint_req_o=0.
  - bus_o=0 while rst_i=0.
- Synchronizer: every input passes through 2 flops (s1, s2). A prev flop holds the last s2.
  - An edge is detected when s2 != prev.
  - Input change before edge E0 → s1 at E0 → s2 at E1 → flag set at E2. Flag and req are visible after E2.
- Arm counter: 2-bit, increments after reset release and saturates at 3. Edge detection is suppressed until it reaches 3, so reset never produces spurious flags.
- INTn sense (EICRA bits [2n+1:2n]):
  - 00 = low level: no flag; int_req_o[n] = EIMSK[n] & ~s2[n], combinational from registers.
  - 01 = any edge.
  - 10 = falling edge.
  - 11 = rising edge.
  - Edge modes set EIFR[n]. int_req_o[n] = EIMSK[n] & EIFR[n].
- Flags set regardless of EIMSK; the mask gates only the request.
- Pin change: PCIFR[0] is set when any bit of (edge & PCMSK & PINMASK) is 1, regardless of PCICR[0]. pcint_req_o = PCICR[0] & PCIFR[0].
- Flag clear:
  - Ack input high for one cycle clears the corresponding flag at that edge.
  - A bus write of 1 to a flag bit clears it; writing 0 has no effect.
- Simultaneous set and clear in the same cycle (ack or write-1): set wins, so the event is not lost.
- EICRA change while armed: the new sense mode applies from the next edge. No flag is generated by the mode switch itself.
- Register writes: whole-register load on wr_i with a matching full address. Unimplemented EICRA/EIMSK bits beyond EXT_WIDTH read 0.
- Reads:
  - bus_o returns the addressed register when rd_i=1 and rst_i=1, else 0.
  - Unknown address → 0.
  - Read has no side effects.

Test Plan:
- Reset, then hold io_i='hFF, int_i=2'b11 for 10 cycles → all flags 0, int_req_o=0, pcint_req_o=0, every register reads 'h00.
- EICRA='h03 (INT0 rising), EIMSK='h01; int_i[0] 0→1 before edge E0 → EIFR reads 'h01 and int_req_o[0]=1 after E2. int_ack_i[0] pulse clears both on the next edge.
- EICRA='h02 (falling): a rising edge gives no flag. Then EICRA='h00 (level) with int_i[0]=0 → int_req_o[0]=1 while the pin is low and EIFR=0; releasing the pin drops the request 2 cycles later.
- PCMSK='h04, PCICR='h01; toggle io_i[3] → no flag. Toggle io_i[2] → PCIFR='h01 and pcint_req_o=1 after E2. Writing 'h01 to PCIFR clears it.
- Set PCIFR, then in a single cycle both assert pcint_ack_i and deliver a new masked edge → PCIFR stays 1.
- PCICR=0 with a masked edge → PCIFR=1, pcint_req_o=0. Setting PCICR='h01 → pcint_req_o=1 on the next cycle.

Source files
------------

// File: rtl/atmega_exint.sv
// ATmega INTn / pin-change interrupt controller: inputs pass through two sync flops, and flags set two edges after an input change.
// Register reads are combinational; flag set wins over a same-cycle ack or write-1 clear. There is no backpressure.
module atmega_exint #(
  parameter int                    BUS_ADDR_DATA_LEN = 8,
  parameter int                    PORT_WIDTH        = 8,
  parameter int                    EXT_WIDTH         = 2,
  parameter int                    EICRA_ADDR        = 'h69,
  parameter int                    EIMSK_ADDR        = 'h3D,
  parameter int                    EIFR_ADDR         = 'h3C,
  parameter int                    PCICR_ADDR        = 'h68,
  parameter int                    PCIFR_ADDR        = 'h3B,
  parameter int                    PCMSK_ADDR        = 'h6B,
  parameter logic [PORT_WIDTH-1:0] PINMASK           = 'hFF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
  input  logic                         wr_i,
  input  logic                         rd_i,
  input  logic [7:0]                   bus_i,
  output logic [7:0]                   bus_o,
  input  logic [PORT_WIDTH-1:0]        io_i,
  input  logic [EXT_WIDTH-1:0]         int_i,
  output logic [EXT_WIDTH-1:0]         int_req_o,
  input  logic [EXT_WIDTH-1:0]         int_ack_i,
  output logic                         pcint_req_o,
  input  logic                         pcint_ack_i
);

  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_EICRA = BUS_ADDR_DATA_LEN'(EICRA_ADDR);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_EIMSK = BUS_ADDR_DATA_LEN'(EIMSK_ADDR);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_EIFR  = BUS_ADDR_DATA_LEN'(EIFR_ADDR);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_PCICR = BUS_ADDR_DATA_LEN'(PCICR_ADDR);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_PCIFR = BUS_ADDR_DATA_LEN'(PCIFR_ADDR);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_PCMSK = BUS_ADDR_DATA_LEN'(PCMSK_ADDR);

  logic [PORT_WIDTH-1:0]  r_io_s1, r_io_s2, r_io_prev;
  logic [EXT_WIDTH-1:0]   r_int_s1, r_int_s2, r_int_prev;
  logic [1:0]             r_arm;
  logic [2*EXT_WIDTH-1:0] r_eicra;
  logic [EXT_WIDTH-1:0]   r_eimsk, r_eifr;
  logic                   r_pcicr, r_pcifr;
  logic [PORT_WIDTH-1:0]  r_pcmsk;

  logic                   w_armed;
  logic                   w_wr_eicra, w_wr_eimsk, w_wr_eifr, w_wr_pcicr, w_wr_pcifr, w_wr_pcmsk;
  logic [EXT_WIDTH-1:0]   w_int_rise, w_int_fall, w_int_set, w_int_clr;
  logic [PORT_WIDTH-1:0]  w_io_edge;
  logic                   w_pc_set, w_pc_clr;

  assign w_armed    = (r_arm == 2'd3);
  assign w_wr_eicra = wr_i && (addr_i == A_EICRA);
  assign w_wr_eimsk = wr_i && (addr_i == A_EIMSK);
  assign w_wr_eifr  = wr_i && (addr_i == A_EIFR);
  assign w_wr_pcicr = wr_i && (addr_i == A_PCICR);
  assign w_wr_pcifr = wr_i && (addr_i == A_PCIFR);
  assign w_wr_pcmsk = wr_i && (addr_i == A_PCMSK);

  assign w_int_rise = r_int_s2 & ~r_int_prev;
  assign w_int_fall = ~r_int_s2 & r_int_prev;
  assign w_io_edge  = r_io_s2 ^ r_io_prev;

  assign w_int_clr  = int_ack_i | (w_wr_eifr ? bus_i[EXT_WIDTH-1:0] : '0);
  assign w_pc_set   = w_armed && |(w_io_edge & r_pcmsk & PINMASK);
  assign w_pc_clr   = pcint_ack_i | (w_wr_pcifr & bus_i[0]);

  // Level mode bypasses the flag and requests straight from the synchronized pin.
  always_comb begin
    w_int_set = '0;
    int_req_o = '0;
    for (int n = 0; n < EXT_WIDTH; n++) begin
      case (r_eicra[2*n +: 2])
        2'b00: int_req_o[n] = r_eimsk[n] & ~r_int_s2[n];
        2'b01: begin
          w_int_set[n] = w_armed & (w_int_rise[n] | w_int_fall[n]);
          int_req_o[n] = r_eimsk[n] & r_eifr[n];
        end
        2'b10: begin
          w_int_set[n] = w_armed & w_int_fall[n];
          int_req_o[n] = r_eimsk[n] & r_eifr[n];
        end
        default: begin
          w_int_set[n] = w_armed & w_int_rise[n];
          int_req_o[n] = r_eimsk[n] & r_eifr[n];
        end
      endcase
    end
  end

  assign pcint_req_o = r_pcicr & r_pcifr;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_io_s1    <= io_i;
      r_io_s2    <= io_i;
      r_io_prev  <= io_i;
      r_int_s1   <= int_i;
      r_int_s2   <= int_i;
      r_int_prev <= int_i;
      r_arm      <= 2'd0;
      r_eicra    <= '0;
      r_eimsk    <= '0;
      r_eifr     <= '0;
      r_pcicr    <= 1'b0;
      r_pcifr    <= 1'b0;
      r_pcmsk    <= '0;
    end else begin
      r_io_s1    <= io_i;
      r_io_s2    <= r_io_s1;
      r_io_prev  <= r_io_s2;
      r_int_s1   <= int_i;
      r_int_s2   <= r_int_s1;
      r_int_prev <= r_int_s2;
      if (!w_armed) r_arm <= r_arm + 2'd1;
      if (w_wr_eicra) r_eicra <= bus_i[2*EXT_WIDTH-1:0];
      if (w_wr_eimsk) r_eimsk <= bus_i[EXT_WIDTH-1:0];
      if (w_wr_pcicr) r_pcicr <= bus_i[0];
      if (w_wr_pcmsk) r_pcmsk <= bus_i[PORT_WIDTH-1:0] & PINMASK;
      r_eifr  <= (r_eifr & ~w_int_clr) | w_int_set;
      r_pcifr <= (r_pcifr & ~w_pc_clr) | w_pc_set;
    end
  end

  always_comb begin
    bus_o = 8'h00;
    if (rd_i && rst_i) begin
      if      (addr_i == A_EICRA) bus_o = 8'(r_eicra);
      else if (addr_i == A_EIMSK) bus_o = 8'(r_eimsk);
      else if (addr_i == A_EIFR)  bus_o = 8'(r_eifr);
      else if (addr_i == A_PCICR) bus_o = 8'(r_pcicr);
      else if (addr_i == A_PCIFR) bus_o = 8'(r_pcifr);
      else if (addr_i == A_PCMSK) bus_o = 8'(r_pcmsk);
    end
  end

endmodule

// File: tb/tb_atmega_exint.sv
// Directed bench for atmega_exint: inputs change 1 ns after a rising edge, and outputs are compared 1-2 ns after it.
module tb_atmega_exint;

  localparam logic [7:0] EICRA = 8'h69, EIMSK = 8'h3D, EIFR = 8'h3C;
  localparam logic [7:0] PCICR = 8'h68, PCIFR = 8'h3B, PCMSK = 8'h6B;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] addr = '0;
  logic       wr = 1'b0, rd = 1'b0;
  logic [7:0] wdat = '0;
  logic [7:0] rdat;
  logic [7:0] io = 8'hFF;
  logic [1:0] intp = 2'b11;
  logic [1:0] int_req;
  logic [1:0] int_ack = '0;
  logic       pc_req;
  logic       pc_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  atmega_exint dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .wr_i(wr), .rd_i(rd),
    .bus_i(wdat), .bus_o(rdat), .io_i(io), .int_i(intp),
    .int_req_o(int_req), .int_ack_i(int_ack),
    .pcint_req_o(pc_req), .pcint_ack_i(pc_ack)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wreg(input logic [7:0] a, input logic [7:0] d);
    addr = a;
    wdat = d;
    wr   = 1'b1;
    tick();
    wr   = 1'b0;
  endtask

  task automatic rchk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    rd   = 1'b1;
    #1;
    chk(tag, rdat, exp);
    rd   = 1'b0;
  endtask

  initial begin
    // Reset and idle
    tick(2);
    rchk("bus_in_reset", EICRA, 8'h00);
    chk("int_req_in_reset", {6'b0, int_req}, 8'h00);
    rst = 1'b1;
    tick(10);
    chk("int_req_idle", {6'b0, int_req}, 8'h00);
    chk("pc_req_idle", {7'b0, pc_req}, 8'h00);
    rchk("eicra_rst", EICRA, 8'h00);
    rchk("eimsk_rst", EIMSK, 8'h00);
    rchk("eifr_rst",  EIFR,  8'h00);
    rchk("pcicr_rst", PCICR, 8'h00);
    rchk("pcifr_rst", PCIFR, 8'h00);
    rchk("pcmsk_rst", PCMSK, 8'h00);

    // INT0 rising edge
    wreg(EICRA, 8'h03);
    wreg(EIMSK, 8'h01);
    intp[0] = 1'b0;
    tick(4);
    rchk("rise_ignores_fall", EIFR, 8'h00);
    intp[0] = 1'b1;
    tick(2);
    chk("rise_not_before_e2", {6'b0, int_req}, 8'h00);
    tick();
    rchk("rise_flag", EIFR, 8'h01);
    chk("rise_req", {6'b0, int_req}, 8'h01);
    int_ack[0] = 1'b1;
    tick();
    int_ack[0] = 1'b0;
    rchk("ack_clears_flag", EIFR, 8'h00);
    chk("ack_clears_req", {6'b0, int_req}, 8'h00);

    // INT0 falling edge, then low level
    intp[0] = 1'b0;
    tick(4);
    wreg(EICRA, 8'h02);
    intp[0] = 1'b1;
    tick(4);
    rchk("fall_ignores_rise", EIFR, 8'h00);
    intp[0] = 1'b0;
    tick(3);
    rchk("fall_flag", EIFR, 8'h01);
    wreg(EIFR, 8'h00);
    rchk("w0_no_clear", EIFR, 8'h01);
    wreg(EIFR, 8'h01);
    rchk("w1_clear", EIFR, 8'h00);
    wreg(EICRA, 8'h00);
    chk("level_req", {6'b0, int_req}, 8'h01);
    rchk("level_no_flag", EIFR, 8'h00);
    intp[0] = 1'b1;
    tick();
    chk("level_req_hold", {6'b0, int_req}, 8'h01);
    tick();
    chk("level_req_drop", {6'b0, int_req}, 8'h00);

    // INT1 any edge while masked; unimplemented bits and unknown address
    wreg(EICRA, 8'h04);
    intp[1] = 1'b0;
    tick(3);
    rchk("int1_flag_masked", EIFR, 8'h02);
    chk("int1_no_req", {6'b0, int_req}, 8'h00);
    wreg(EIMSK, 8'hFF);
    rchk("eimsk_unimpl", EIMSK, 8'h03);
    chk("int1_req", {6'b0, int_req}, 8'h02);
    wreg(EIMSK, 8'h01);
    wreg(EIFR, 8'h02);
    rchk("unknown_addr", 8'h20, 8'h00);

    // Pin change
    wreg(PCMSK, 8'h04);
    wreg(PCICR, 8'h01);
    io = 8'hF7;
    tick(4);
    io = 8'hFF;
    tick(4);
    rchk("pc_unmasked_ignored", PCIFR, 8'h00);
    chk("pc_unmasked_no_req", {7'b0, pc_req}, 8'h00);
    io = 8'hFB;
    tick(2);
    chk("pc_not_before_e2", {7'b0, pc_req}, 8'h00);
    tick();
    rchk("pc_flag", PCIFR, 8'h01);
    chk("pc_req", {7'b0, pc_req}, 8'h01);
    wreg(PCIFR, 8'h01);
    rchk("pc_w1_clear", PCIFR, 8'h00);

    // Set wins over a same-cycle ack
    io = 8'hFF;
    tick(3);
    rchk("pc_flag_again", PCIFR, 8'h01);
    io = 8'hFB;
    tick(2);
    pc_ack = 1'b1;
    tick();
    pc_ack = 1'b0;
    rchk("set_beats_ack", PCIFR, 8'h01);
    pc_ack = 1'b1;
    tick();
    pc_ack = 1'b0;
    rchk("pc_ack_clear", PCIFR, 8'h00);

    // Flag set with the enable off; the request follows the enable
    wreg(PCICR, 8'h00);
    io = 8'hFF;
    tick(3);
    rchk("pc_flag_disabled", PCIFR, 8'h01);
    chk("pc_req_disabled", {7'b0, pc_req}, 8'h00);
    wreg(PCICR, 8'h01);
    chk("pc_req_enabled", {7'b0, pc_req}, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
